csr_regfile: RTL and testbench

//  Control/status register file answering the WB-stage CSR port. Serves

---
 rtl/csr_regfile_pkg.sv | 52 +++++
 rtl/csr_timer.sv | 62 ++++++
 rtl/csr_regfile.sv | 147 ++++++++++++++
 tb/tb_csr_regfile.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/csr_regfile_pkg.sv
// Shared CSR definitions: addresses, field positions, writable-field masks, ecodes
// and the masked-merge helper used by every writable CSR.
package csr_regfile_pkg;

    localparam logic [13:0] CSR_CRMD   = 14'h000;
    localparam logic [13:0] CSR_PRMD   = 14'h001;
    localparam logic [13:0] CSR_ECFG   = 14'h004;
    localparam logic [13:0] CSR_ESTAT  = 14'h005;
    localparam logic [13:0] CSR_ERA    = 14'h006;
    localparam logic [13:0] CSR_BADV   = 14'h007;
    localparam logic [13:0] CSR_EENTRY = 14'h00C;
    localparam logic [13:0] CSR_SAVE0  = 14'h030;
    localparam logic [13:0] CSR_TID    = 14'h040;
    localparam logic [13:0] CSR_TCFG   = 14'h041;
    localparam logic [13:0] CSR_TVAL   = 14'h042;
    localparam logic [13:0] CSR_TICLR  = 14'h044;

    localparam int NUM_SAVE = 4;

    // Writable fields; everything outside these reads as zero.
    localparam logic [31:0] CRMD_WMASK   = 32'h0000_01FF;
    localparam logic [31:0] PRMD_WMASK   = 32'h0000_0007;
    localparam logic [31:0] ECFG_WMASK   = 32'h0000_1BFF;
    localparam logic [31:0] EENTRY_WMASK = 32'hFFFF_FFC0;
    localparam logic [31:0] FULL_WMASK   = 32'hFFFF_FFFF;

    localparam logic [31:0] CRMD_RESET   = 32'h0000_0008;

    localparam int CRMD_IE       = 2;
    localparam int PRMD_PIE      = 2;
    localparam int ESTAT_IS_HW   = 2;
    localparam int ESTAT_IS_TI   = 11;
    localparam int ESTAT_IS_IPI  = 12;
    localparam int ESTAT_ECODE   = 16;
    localparam int ESTAT_ESUB    = 22;

    typedef enum logic [5:0] {
        ECODE_ADE = 6'h08,
        ECODE_ALE = 6'h09,
        ECODE_SYS = 6'h0B
    } ecode_e;

    function automatic logic [31:0] wr_merge(input logic [31:0] old_val,
                                             input logic [31:0] wvalue,
                                             input logic [31:0] wmask,
                                             input logic [31:0] field);
        logic [31:0] m;
        m = wmask & field;
        return (old_val & ~m) | (wvalue & m);
    endfunction

endpackage

// File: rtl/csr_timer.sv
// Stable timer: TCFG/TVAL state plus the sticky timer interrupt (ESTAT.IS[11]).
module csr_timer
    import csr_regfile_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        tcfg_we,
    input  logic        ticlr_we,
    input  logic [31:0] csr_wmask,
    input  logic [31:0] csr_wvalue,
    output logic [31:0] tcfg,
    output logic [31:0] tval,
    output logic        timer_int
);

    logic [31:0] tcfg_reg;
    logic [31:0] tval_reg;
    logic        timer_int_reg;
    logic [31:0] tcfg_next;
    logic        timer_en;
    logic        timer_periodic;
    logic        timer_hit;
    logic        ticlr_hit;

    assign tcfg_next      = wr_merge(tcfg_reg, csr_wvalue, csr_wmask, FULL_WMASK);
    assign timer_en       = tcfg_reg[0];
    assign timer_periodic = tcfg_reg[1];
    assign timer_hit      = timer_en && (tval_reg == 32'h0);
    assign ticlr_hit      = ticlr_we && csr_wmask[0] && csr_wvalue[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            tcfg_reg      <= 32'h0;
            tval_reg      <= 32'hFFFF_FFFF;
            timer_int_reg <= 1'b0;
        end else begin
            if (tcfg_we) begin
                tcfg_reg <= tcfg_next;
            end

            // One-shot mode decrements 0 into all-ones and parks there.
            if (tcfg_we) begin
                tval_reg <= {tcfg_next[31:2], 2'b00};
            end else if (timer_hit && timer_periodic) begin
                tval_reg <= {tcfg_reg[31:2], 2'b00};
            end else if (timer_en && (tval_reg != 32'hFFFF_FFFF)) begin
                tval_reg <= tval_reg - 32'h1;
            end

            if (timer_hit) begin
                timer_int_reg <= 1'b1;
            end else if (ticlr_hit) begin
                timer_int_reg <= 1'b0;
            end
        end
    end

    assign tcfg      = tcfg_reg;
    assign tval      = tval_reg;
    assign timer_int = timer_int_reg;

endmodule

// File: rtl/csr_regfile.sv
// WB-stage CSR file: zero-latency reads, masked writes, exception entry/return
// state updates, interrupt aggregation, and the stable timer.
module csr_regfile
    import csr_regfile_pkg::*;
#(
    parameter logic [31:0] TID_RESET = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] csr_num,
    input  logic        csr_re,
    output logic [31:0] csr_rvalue,
    input  logic        csr_we,
    input  logic [31:0] csr_wmask,
    input  logic [31:0] csr_wvalue,
    input  logic        wb_ex,
    input  logic [31:0] wb_csr_pc,
    input  logic [5:0]  wb_ecode,
    input  logic [8:0]  wb_esubcode,
    input  logic [31:0] wb_vaddr,
    input  logic        ertn_flush,
    input  logic [7:0]  hw_int_in,
    input  logic        ipi_int_in,
    output logic [31:0] ex_entry,
    output logic [31:0] ertn_era,
    output logic        has_int
);

    logic [31:0] crmd_reg;
    logic [31:0] prmd_reg;
    logic [31:0] ecfg_reg;
    logic [31:0] estat_reg;
    logic [31:0] era_reg;
    logic [31:0] badv_reg;
    logic [31:0] eentry_reg;
    logic [31:0] tid_reg;
    logic [NUM_SAVE-1:0][31:0] save_val;

    logic [31:0] tcfg_val;
    logic [31:0] tval_val;
    logic        timer_int;
    logic [31:0] estat_val;
    logic        csr_wr;
    logic [31:0] rdata;

    // Exception entry and ertn both suppress a same-cycle CSR write.
    assign csr_wr = csr_we && !wb_ex && !ertn_flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            crmd_reg   <= CRMD_RESET;
            prmd_reg   <= 32'h0;
            ecfg_reg   <= 32'h0;
            estat_reg  <= 32'h0;
            era_reg    <= 32'h0;
            badv_reg   <= 32'h0;
            eentry_reg <= 32'h0;
            tid_reg    <= TID_RESET;
        end else begin
            estat_reg[ESTAT_IS_HW +: 8] <= hw_int_in;
            estat_reg[ESTAT_IS_IPI]     <= ipi_int_in;

            if (wb_ex) begin
                prmd_reg[1:0]               <= crmd_reg[1:0];
                prmd_reg[PRMD_PIE]          <= crmd_reg[CRMD_IE];
                crmd_reg[2:0]               <= 3'b000;
                era_reg                     <= wb_csr_pc;
                estat_reg[ESTAT_ECODE +: 6] <= wb_ecode;
                estat_reg[ESTAT_ESUB +: 9]  <= wb_esubcode;
                if (wb_ecode == ECODE_ADE || wb_ecode == ECODE_ALE) begin
                    badv_reg <= wb_vaddr;
                end
            end else if (ertn_flush) begin
                crmd_reg[2:0] <= prmd_reg[2:0];
            end else if (csr_wr) begin
                case (csr_num)
                    CSR_CRMD:   crmd_reg   <= wr_merge(crmd_reg, csr_wvalue, csr_wmask, CRMD_WMASK);
                    CSR_PRMD:   prmd_reg   <= wr_merge(prmd_reg, csr_wvalue, csr_wmask, PRMD_WMASK);
                    CSR_ECFG:   ecfg_reg   <= wr_merge(ecfg_reg, csr_wvalue, csr_wmask, ECFG_WMASK);
                    CSR_ESTAT:  estat_reg[1:0] <= (estat_reg[1:0] & ~csr_wmask[1:0])
                                                | (csr_wvalue[1:0] & csr_wmask[1:0]);
                    CSR_ERA:    era_reg    <= wr_merge(era_reg, csr_wvalue, csr_wmask, FULL_WMASK);
                    CSR_BADV:   badv_reg   <= wr_merge(badv_reg, csr_wvalue, csr_wmask, FULL_WMASK);
                    CSR_EENTRY: eentry_reg <= wr_merge(eentry_reg, csr_wvalue, csr_wmask, EENTRY_WMASK);
                    CSR_TID:    tid_reg    <= wr_merge(tid_reg, csr_wvalue, csr_wmask, FULL_WMASK);
                    default: ;
                endcase
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SAVE; gi++) begin : g_save
            logic [31:0] save_reg;
            always_ff @(posedge clk) begin
                if (reset) begin
                    save_reg <= 32'h0;
                end else if (csr_wr && (csr_num == CSR_SAVE0 + 14'(gi))) begin
                    save_reg <= wr_merge(save_reg, csr_wvalue, csr_wmask, FULL_WMASK);
                end
            end
            assign save_val[gi] = save_reg;
        end
    endgenerate

    csr_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .tcfg_we    (csr_wr && (csr_num == CSR_TCFG)),
        .ticlr_we   (csr_wr && (csr_num == CSR_TICLR)),
        .csr_wmask  (csr_wmask),
        .csr_wvalue (csr_wvalue),
        .tcfg       (tcfg_val),
        .tval       (tval_val),
        .timer_int  (timer_int)
    );

    assign estat_val = estat_reg | (32'(timer_int) << ESTAT_IS_TI);

    always_comb begin
        rdata = 32'h0;
        case (csr_num)
            CSR_CRMD:   rdata = crmd_reg;
            CSR_PRMD:   rdata = prmd_reg;
            CSR_ECFG:   rdata = ecfg_reg;
            CSR_ESTAT:  rdata = estat_val;
            CSR_ERA:    rdata = era_reg;
            CSR_BADV:   rdata = badv_reg;
            CSR_EENTRY: rdata = eentry_reg;
            CSR_SAVE0:  rdata = save_val[0];
            CSR_SAVE0 + 14'd1: rdata = save_val[1];
            CSR_SAVE0 + 14'd2: rdata = save_val[2];
            CSR_SAVE0 + 14'd3: rdata = save_val[3];
            CSR_TID:    rdata = tid_reg;
            CSR_TCFG:   rdata = tcfg_val;
            CSR_TVAL:   rdata = tval_val;
            default:    rdata = 32'h0;
        endcase
    end

    assign csr_rvalue = csr_re ? rdata : 32'h0;
    assign ex_entry   = eentry_reg;
    assign ertn_era   = era_reg;
    assign has_int    = crmd_reg[CRMD_IE] && |(estat_val[12:0] & ecfg_reg[12:0]);

endmodule

// File: tb/tb_csr_regfile.sv
// Directed bench for csr_regfile: register map, exception/ertn flow, IS sampling,
// periodic and one-shot timer, reset during countdown.
module tb_csr_regfile;
    import csr_regfile_pkg::*;

    localparam logic [31:0] TID_INIT = 32'hCAFE_0001;

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] csr_num;
    logic        csr_re;
    logic [31:0] csr_rvalue;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        wb_ex;
    logic [31:0] wb_csr_pc;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_vaddr;
    logic        ertn_flush;
    logic [7:0]  hw_int_in;
    logic        ipi_int_in;
    logic [31:0] ex_entry;
    logic [31:0] ertn_era;
    logic        has_int;

    int errors = 0;
    int checks = 0;

    csr_regfile #(.TID_RESET(TID_INIT)) dut (
        .clk         (clk),
        .reset       (reset),
        .csr_num     (csr_num),
        .csr_re      (csr_re),
        .csr_rvalue  (csr_rvalue),
        .csr_we      (csr_we),
        .csr_wmask   (csr_wmask),
        .csr_wvalue  (csr_wvalue),
        .wb_ex       (wb_ex),
        .wb_csr_pc   (wb_csr_pc),
        .wb_ecode    (wb_ecode),
        .wb_esubcode (wb_esubcode),
        .wb_vaddr    (wb_vaddr),
        .ertn_flush  (ertn_flush),
        .hw_int_in   (hw_int_in),
        .ipi_int_in  (ipi_int_in),
        .ex_entry    (ex_entry),
        .ertn_era    (ertn_era),
        .has_int     (has_int)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
        $display("check %-14s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic rd(input logic [13:0] addr, output logic [31:0] val);
        csr_num = addr;
        #1;
        val = csr_rvalue;
    endtask

    task automatic check_rd(input string tag, input logic [13:0] addr, input logic [31:0] exp);
        logic [31:0] v;
        rd(addr, v);
        check(tag, v, exp);
    endtask

    task automatic wr(input logic [13:0] addr, input logic [31:0] val, input logic [31:0] mask);
        csr_num    = addr;
        csr_wvalue = val;
        csr_wmask  = mask;
        csr_we     = 1'b1;
        step();
        csr_we     = 1'b0;
    endtask

    initial begin
        logic [31:0] v;
        reset = 1'b1; csr_num = '0; csr_re = 1'b1; csr_we = 1'b0;
        csr_wmask = '0; csr_wvalue = '0; wb_ex = 1'b0; wb_csr_pc = '0;
        wb_ecode = '0; wb_esubcode = '0; wb_vaddr = '0; ertn_flush = 1'b0;
        hw_int_in = '0; ipi_int_in = 1'b0;
        step(); step();
        reset = 1'b0;

        // Reset state
        check_rd("rst_crmd", CSR_CRMD, 32'h8);
        check_rd("rst_tid", CSR_TID, TID_INIT);
        check_rd("rst_tval", CSR_TVAL, 32'hFFFF_FFFF);
        check_rd("rst_prmd", CSR_PRMD, 32'h0);
        check_rd("rst_estat", CSR_ESTAT, 32'h0);
        check("rst_ex_entry", ex_entry, 32'h0);
        check("rst_ertn_era", ertn_era, 32'h0);
        check("rst_has_int", {31'b0, has_int}, 32'h0);

        // Masked write to SAVE0
        wr(CSR_SAVE0, 32'h1234_5678, 32'hFFFF_FFFF);
        wr(CSR_SAVE0, 32'hAAAA_5555, 32'h0000_FFFF);
        check_rd("save0_masked", CSR_SAVE0, 32'h1234_5555);

        // Unimplemented address and field masks
        wr(14'h002, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check_rd("unimpl_rd", 14'h002, 32'h0);
        wr(CSR_EENTRY, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check_rd("eentry_field", CSR_EENTRY, 32'hFFFF_FFC0);
        check("ex_entry", ex_entry, 32'hFFFF_FFC0);
        check_rd("ticlr_rd", CSR_TICLR, 32'h0);

        // PLV=3, IE=1, then exception entry (SYS)
        wr(CSR_CRMD, 32'h7, 32'h7);
        check_rd("crmd_plv3ie", CSR_CRMD, 32'hF);
        wb_ex = 1'b1; wb_csr_pc = 32'h1C00_0100; wb_ecode = ECODE_SYS;
        wb_esubcode = 9'h0; wb_vaddr = 32'hDEAD_0000;
        step();
        wb_ex = 1'b0;
        check_rd("ex_crmd", CSR_CRMD, 32'h8);
        check_rd("ex_prmd", CSR_PRMD, 32'h7);
        check_rd("ex_era", CSR_ERA, 32'h1C00_0100);
        check("ertn_era", ertn_era, 32'h1C00_0100);
        check_rd("ex_estat", CSR_ESTAT, 32'h000B_0000);
        check_rd("ex_badv_keep", CSR_BADV, 32'h0);

        ertn_flush = 1'b1;
        step();
        ertn_flush = 1'b0;
        check_rd("ertn_crmd", CSR_CRMD, 32'hF);

        // Exception (ALE) with a simultaneous CSR write that must be dropped
        wb_ex = 1'b1; wb_ecode = ECODE_ALE; wb_vaddr = 32'h3; wb_csr_pc = 32'h1C00_0200;
        csr_we = 1'b1; csr_num = CSR_SAVE0 + 14'd1;
        csr_wvalue = 32'hFFFF_FFFF; csr_wmask = 32'hFFFF_FFFF;
        step();
        wb_ex = 1'b0; csr_we = 1'b0;
        check_rd("ale_badv", CSR_BADV, 32'h3);
        check_rd("ale_save1", CSR_SAVE0 + 14'd1, 32'h0);
        check_rd("ale_crmd", CSR_CRMD, 32'h8);

        // Interrupt-line sampling and software IS bits
        hw_int_in = 8'hA5; ipi_int_in = 1'b1;
        step();
        check_rd("is_sample", CSR_ESTAT, 32'h0009_1294);
        wr(CSR_ESTAT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check_rd("is_sw_wr", CSR_ESTAT, 32'h0009_1297);
        hw_int_in = 8'h0; ipi_int_in = 1'b0;
        wr(CSR_ESTAT, 32'h0, 32'h3);
        check_rd("is_clear", CSR_ESTAT, 32'h0009_0000);

        // Periodic timer: restore IE, enable LIE[11], InitVal=8
        ertn_flush = 1'b1;
        step();
        ertn_flush = 1'b0;
        wr(CSR_ECFG, 32'h0000_0800, 32'hFFFF_FFFF);
        check_rd("ecfg", CSR_ECFG, 32'h800);
        wr(CSR_TCFG, 32'h0000_000B, 32'hFFFF_FFFF);
        for (int k = 8; k >= 0; k--) begin
            check_rd($sformatf("per_tval%0d", k), CSR_TVAL, 32'(k));
            if (k == 0) check("per_noint", {31'b0, has_int}, 32'h0);
            step();
        end
        check_rd("per_reload", CSR_TVAL, 32'h8);
        rd(CSR_ESTAT, v);
        check("per_is11", {31'b0, v[11]}, 32'h1);
        check("per_has_int", {31'b0, has_int}, 32'h1);

        wr(CSR_TICLR, 32'h1, 32'h1);
        rd(CSR_ESTAT, v);
        check("ticlr_is11", {31'b0, v[11]}, 32'h0);
        check("ticlr_has_int", {31'b0, has_int}, 32'h0);

        // One-shot timer
        wr(CSR_TCFG, 32'h0000_0009, 32'hFFFF_FFFF);
        check_rd("os_tcfg", CSR_TCFG, 32'h9);
        csr_num = CSR_TVAL;
        repeat (8) step();
        check_rd("os_tval0", CSR_TVAL, 32'h0);
        step();
        check_rd("os_wrap", CSR_TVAL, 32'hFFFF_FFFF);
        check("os_has_int", {31'b0, has_int}, 32'h1);
        step(); step();
        check_rd("os_hold", CSR_TVAL, 32'hFFFF_FFFF);

        // Reset in the middle of a countdown
        wr(CSR_TCFG, 32'h0000_000B, 32'hFFFF_FFFF);
        repeat (3) step();
        check_rd("mid_tval5", CSR_TVAL, 32'h5);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_rd("rst2_tval", CSR_TVAL, 32'hFFFF_FFFF);
        check("rst2_has_int", {31'b0, has_int}, 32'h0);
        check_rd("rst2_tcfg", CSR_TCFG, 32'h0);
        check_rd("rst2_save0", CSR_SAVE0, 32'h0);
        check("rst2_ex_entry", ex_entry, 32'h0);
        repeat (3) step();
        check_rd("rst2_tval_hold", CSR_TVAL, 32'hFFFF_FFFF);
        rd(CSR_ESTAT, v);
        check("rst2_is11", {31'b0, v[11]}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
